pipeline_hazard_ctrl: RTL and testbench

Interlock controller for the in-order pipeline. It generates the per-stage `update` enables and bubble/flush strobes consumed by the pipeline registers (fetch/decode, readreg, execute, memory). It consumes the readreg stage's `loads` flag and destination register number to detect load-use hazards, and it serialises memory-busy stalls and taken-branch flushes through a small FSM.

---
 rtl/pipeline_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Interlock controller for the in-order pipeline: load-use bubbles, memory-busy
// freezes and taken-branch flushes, serialised through a four-state FSM.
module pipeline_hazard_ctrl #(
    parameter int LU_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        loads_rr,
    input  logic [2:0]  num_Rd_rr,
    input  logic [2:0]  num_Rm_dec,
    input  logic [2:0]  num_Rn_dec,
    input  logic [2:0]  num_Rd_dec,
    input  logic [2:0]  used_RmRnRd_dec,
    input  logic        mem_busy,
    input  logic        branch_taken,
    output logic        update_fetch,
    output logic        update_rr,
    output logic        update_ex,
    output logic        update_mem,
    output logic        bubble_rr,
    output logic        bubble_ex,
    output logic        flush_fetch,
    output logic [15:0] stall_cycles,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    // A single-bubble hazard is fully handled in the detecting cycle, so the
    // FSM only enters LU_STALL when more than one bubble is needed.
    localparam logic [1:0] LU_LOAD = 2'(LU_BUBBLES - 1);
    localparam state_t     HZ_NEXT = (LU_BUBBLES > 1) ? LU_STALL : RUN;

    state_t     cur_state;
    state_t     nxt_state;
    logic [1:0] lu_cnt;
    logic [1:0] lu_nxt;
    logic       hz;

    logic       upd_fetch_c;
    logic       upd_rr_c;
    logic       upd_ex_c;
    logic       upd_mem_c;
    logic       bub_rr_c;
    logic       bub_ex_c;
    logic       flush_c;

    assign hz = loads_rr &
                ((used_RmRnRd_dec[2] & (num_Rm_dec == num_Rd_rr)) |
                 (used_RmRnRd_dec[1] & (num_Rn_dec == num_Rd_rr)) |
                 (used_RmRnRd_dec[0] & (num_Rd_dec == num_Rd_rr)));

    always_comb begin
        upd_fetch_c = 1'b1;
        upd_rr_c    = 1'b1;
        upd_ex_c    = 1'b1;
        upd_mem_c   = 1'b1;
        bub_rr_c    = 1'b0;
        bub_ex_c    = 1'b0;
        flush_c     = 1'b0;
        nxt_state   = cur_state;
        lu_nxt      = lu_cnt;

        if (!rst) begin
            upd_fetch_c = 1'b0;
            upd_rr_c    = 1'b0;
            upd_ex_c    = 1'b0;
            upd_mem_c   = 1'b0;
            nxt_state   = RUN;
            lu_nxt      = 2'd0;
        end else if (mem_busy) begin
            // Full freeze; only RUN leaves its state, pending work is held.
            upd_fetch_c = 1'b0;
            upd_rr_c    = 1'b0;
            upd_ex_c    = 1'b0;
            upd_mem_c   = 1'b0;
            if (cur_state == RUN) begin
                nxt_state = MEM_WAIT;
            end
        end else begin
            case (cur_state)
                RUN, MEM_WAIT: begin
                    if (branch_taken) begin
                        bub_rr_c  = 1'b1;
                        bub_ex_c  = 1'b1;
                        flush_c   = 1'b1;
                        nxt_state = FLUSH;
                    end else if (hz) begin
                        upd_fetch_c = 1'b0;
                        bub_rr_c    = 1'b1;
                        lu_nxt      = LU_LOAD;
                        nxt_state   = HZ_NEXT;
                    end else begin
                        nxt_state = RUN;
                    end
                end
                LU_STALL: begin
                    if (branch_taken) begin
                        bub_rr_c  = 1'b1;
                        bub_ex_c  = 1'b1;
                        flush_c   = 1'b1;
                        lu_nxt    = 2'd0;
                        nxt_state = FLUSH;
                    end else begin
                        upd_fetch_c = 1'b0;
                        bub_rr_c    = 1'b1;
                        if (lu_cnt <= 2'd1) begin
                            lu_nxt    = 2'd0;
                            nxt_state = RUN;
                        end else begin
                            lu_nxt = lu_cnt - 2'd1;
                        end
                    end
                end
                FLUSH: begin
                    // Wrong-path instruction in execute: its branch flag is ignored.
                    bub_rr_c  = 1'b1;
                    nxt_state = RUN;
                end
                default: begin
                    nxt_state = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state    <= RUN;
            lu_cnt       <= 2'd0;
            stall_cycles <= 16'd0;
        end else begin
            cur_state <= nxt_state;
            lu_cnt    <= lu_nxt;
            if (!upd_fetch_c && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

    assign update_fetch = upd_fetch_c;
    assign update_rr    = upd_rr_c;
    assign update_ex    = upd_ex_c;
    assign update_mem   = upd_mem_c;
    assign bubble_rr    = bub_rr_c;
    assign bubble_ex    = bub_ex_c;
    assign flush_fetch  = flush_c;
    assign state        = cur_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (LU_BUBBLES = 1, 2, 3) share
// one input set; a vector table plus hand sequences check outputs and counters.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       loads_rr;
    logic [2:0] num_Rd_rr;
    logic [2:0] num_Rm_dec;
    logic [2:0] num_Rn_dec;
    logic [2:0] num_Rd_dec;
    logic [2:0] used_RmRnRd_dec;
    logic       mem_busy;
    logic       branch_taken;

    wire        uf_a, urr_a, uex_a, um_a, brr_a, bex_a, ff_a;
    wire [15:0] sc_a;
    wire [1:0]  st_a;
    wire        uf_b, urr_b, uex_b, um_b, brr_b, bex_b, ff_b;
    wire [15:0] sc_b;
    wire [1:0]  st_b;
    wire        uf_c, urr_c, uex_c, um_c, brr_c, bex_c, ff_c;
    wire [15:0] sc_c;
    wire [1:0]  st_c;

    // Observed word: {update fetch/rr/ex/mem, bubble_rr, bubble_ex, flush_fetch, state}
    wire [8:0] obs_a = {uf_a, urr_a, uex_a, um_a, brr_a, bex_a, ff_a, st_a};
    wire [8:0] obs_b = {uf_b, urr_b, uex_b, um_b, brr_b, bex_b, ff_b, st_b};
    wire [8:0] obs_c = {uf_c, urr_c, uex_c, um_c, brr_c, bex_c, ff_c, st_c};

    pipeline_hazard_ctrl #(.LU_BUBBLES(1)) dut_a (
        .clk(clk), .rst(rst), .loads_rr(loads_rr), .num_Rd_rr(num_Rd_rr),
        .num_Rm_dec(num_Rm_dec), .num_Rn_dec(num_Rn_dec), .num_Rd_dec(num_Rd_dec),
        .used_RmRnRd_dec(used_RmRnRd_dec), .mem_busy(mem_busy), .branch_taken(branch_taken),
        .update_fetch(uf_a), .update_rr(urr_a), .update_ex(uex_a), .update_mem(um_a),
        .bubble_rr(brr_a), .bubble_ex(bex_a), .flush_fetch(ff_a),
        .stall_cycles(sc_a), .state(st_a)
    );

    pipeline_hazard_ctrl #(.LU_BUBBLES(2)) dut_b (
        .clk(clk), .rst(rst), .loads_rr(loads_rr), .num_Rd_rr(num_Rd_rr),
        .num_Rm_dec(num_Rm_dec), .num_Rn_dec(num_Rn_dec), .num_Rd_dec(num_Rd_dec),
        .used_RmRnRd_dec(used_RmRnRd_dec), .mem_busy(mem_busy), .branch_taken(branch_taken),
        .update_fetch(uf_b), .update_rr(urr_b), .update_ex(uex_b), .update_mem(um_b),
        .bubble_rr(brr_b), .bubble_ex(bex_b), .flush_fetch(ff_b),
        .stall_cycles(sc_b), .state(st_b)
    );

    pipeline_hazard_ctrl #(.LU_BUBBLES(3)) dut_c (
        .clk(clk), .rst(rst), .loads_rr(loads_rr), .num_Rd_rr(num_Rd_rr),
        .num_Rm_dec(num_Rm_dec), .num_Rn_dec(num_Rn_dec), .num_Rd_dec(num_Rd_dec),
        .used_RmRnRd_dec(used_RmRnRd_dec), .mem_busy(mem_busy), .branch_taken(branch_taken),
        .update_fetch(uf_c), .update_rr(urr_c), .update_ex(uex_c), .update_mem(um_c),
        .bubble_rr(brr_c), .bubble_ex(bex_c), .flush_fetch(ff_c),
        .stall_cycles(sc_c), .state(st_c)
    );

    typedef struct {
        logic        r;
        logic        ld;
        logic [2:0]  rdrr;
        logic [2:0]  rm;
        logic [2:0]  rn;
        logic [2:0]  rd;
        logic [2:0]  u;
        logic        mb;
        logic        br;
        logic [8:0]  exp;
        logic [15:0] exp_sc;
    } vec_t;

    vec_t tbl[25];
    int   n_vec = 0;
    int   n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic r, input logic ld, input logic [2:0] rdrr,
                                input logic [2:0] rm, input logic [2:0] rn,
                                input logic [2:0] rd, input logic [2:0] u,
                                input logic mb, input logic br,
                                input logic [8:0] e, input logic [15:0] s);
        vec_t v;
        v.r = r; v.ld = ld; v.rdrr = rdrr; v.rm = rm; v.rn = rn; v.rd = rd;
        v.u = u; v.mb = mb; v.br = br; v.exp = e; v.exp_sc = s;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic r, input logic ld, input logic [2:0] rdrr,
                         input logic [2:0] rm, input logic [2:0] rn,
                         input logic [2:0] rd, input logic [2:0] u,
                         input logic mb, input logic br);
        @(negedge clk);
        rst = r; loads_rr = ld; num_Rd_rr = rdrr; num_Rm_dec = rm;
        num_Rn_dec = rn; num_Rd_dec = rd; used_RmRnRd_dec = u;
        mem_busy = mb; branch_taken = br;
        #1;
    endtask

    task automatic idle(input logic mb, input logic br);
        drive(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, mb, br);
    endtask

    task automatic hazard_rd3();
        drive(1'b1, 1'b1, 3'd3, 3'd0, 3'd0, 3'd3, 3'b001, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    initial begin
        rst = 1'b0; loads_rr = 1'b0; num_Rd_rr = 3'd0; num_Rm_dec = 3'd0;
        num_Rn_dec = 3'd0; num_Rd_dec = 3'd0; used_RmRnRd_dec = 3'b000;
        mem_busy = 1'b0; branch_taken = 1'b0;

        //                r  ld rdrr rm    rn    rd    u       mb br  exp              sc
        tbl[0]  = mk(0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 0, 0, 9'b0000_00_0_00, 16'd0);
        tbl[1]  = mk(1, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 0, 0, 9'b1111_00_0_00, 16'd0);
        tbl[2]  = mk(1, 1, 3'd3, 3'd0, 3'd3, 3'd0, 3'b010, 0, 0, 9'b0111_10_0_00, 16'd0);
        tbl[3]  = mk(1, 1, 3'd3, 3'd0, 3'd4, 3'd0, 3'b010, 0, 0, 9'b1111_00_0_00, 16'd1);
        tbl[4]  = mk(1, 1, 3'd3, 3'd0, 3'd3, 3'd0, 3'b000, 0, 0, 9'b1111_00_0_00, 16'd1);
        tbl[5]  = mk(1, 1, 3'd3, 3'd3, 3'd0, 3'd0, 3'b100, 0, 0, 9'b0111_10_0_00, 16'd1);
        tbl[6]  = mk(1, 1, 3'd3, 3'd0, 3'd0, 3'd3, 3'b001, 0, 0, 9'b0111_10_0_00, 16'd2);
        tbl[7]  = mk(1, 0, 3'd3, 3'd0, 3'd0, 3'd3, 3'b001, 0, 0, 9'b1111_00_0_00, 16'd3);
        tbl[8]  = mk(1, 1, 3'd3, 3'd0, 3'd3, 3'd0, 3'b010, 0, 1, 9'b1111_11_1_00, 16'd3);
        tbl[9]  = mk(1, 1, 3'd3, 3'd0, 3'd3, 3'd0, 3'b010, 0, 1, 9'b1111_10_0_11, 16'd3);
        tbl[10] = mk(1, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 0, 0, 9'b1111_00_0_00, 16'd3);
        tbl[11] = mk(1, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 1, 1, 9'b0000_00_0_00, 16'd3);
        tbl[12] = mk(1, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 1, 1, 9'b0000_00_0_10, 16'd4);
        tbl[13] = mk(1, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 0, 1, 9'b1111_11_1_10, 16'd5);
        tbl[14] = mk(1, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 1, 0, 9'b0000_00_0_11, 16'd5);
        tbl[15] = mk(1, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 0, 0, 9'b1111_10_0_11, 16'd6);
        tbl[16] = mk(1, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 0, 0, 9'b1111_00_0_00, 16'd6);
        tbl[17] = mk(1, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 1, 0, 9'b0000_00_0_00, 16'd6);
        tbl[18] = mk(1, 1, 3'd5, 3'd0, 3'd0, 3'd5, 3'b001, 0, 0, 9'b0111_10_0_10, 16'd7);
        tbl[19] = mk(1, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 0, 0, 9'b1111_00_0_00, 16'd8);
        tbl[20] = mk(1, 1, 3'd5, 3'd5, 3'd0, 3'd0, 3'b100, 1, 0, 9'b0000_00_0_00, 16'd8);
        tbl[21] = mk(1, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 0, 0, 9'b1111_00_0_10, 16'd9);
        tbl[22] = mk(1, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 0, 1, 9'b1111_11_1_00, 16'd9);
        tbl[23] = mk(0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 0, 0, 9'b0000_00_0_11, 16'd9);
        tbl[24] = mk(1, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 0, 0, 9'b1111_00_0_00, 16'd0);

        // Clock-and-reset preamble.
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 1'b0);

        // Table: LU_BUBBLES = 1 instance.
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].r, tbl[i].ld, tbl[i].rdrr, tbl[i].rm, tbl[i].rn,
                  tbl[i].rd, tbl[i].u, tbl[i].mb, tbl[i].br);
            check($sformatf("tbl%0d_out", i), 32'(obs_a), 32'(tbl[i].exp));
            check($sformatf("tbl%0d_stall", i), 32'(sc_a), 32'(tbl[i].exp_sc));
        end

        // LU_BUBBLES = 3: three bubbles, state 0,1,1,0.
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 1'b0);
        hazard_rd3();
        check("lu3_c1", 32'(obs_c), 32'(9'b0111_10_0_00));
        idle(1'b0, 1'b0);
        check("lu3_c2", 32'(obs_c), 32'(9'b0111_10_0_01));
        idle(1'b0, 1'b0);
        check("lu3_c3", 32'(obs_c), 32'(9'b0111_10_0_01));
        idle(1'b0, 1'b0);
        check("lu3_c4", 32'(obs_c), 32'(9'b1111_00_0_00));
        check("lu3_stall", 32'(sc_c), 32'd3);
        drive(1'b1, 1'b1, 3'd3, 3'd0, 3'd0, 3'd2, 3'b001, 1'b0, 1'b0);
        check("lu3_nomatch", 32'(obs_c), 32'(9'b1111_00_0_00));
        // Branch resolving during LU_STALL preempts the remaining bubbles.
        hazard_rd3();
        check("lu3_hz2", 32'(obs_c), 32'(9'b0111_10_0_00));
        idle(1'b0, 1'b1);
        check("lu3_branch", 32'(obs_c), 32'(9'b1111_11_1_01));
        idle(1'b0, 1'b0);
        check("lu3_flush", 32'(obs_c), 32'(9'b1111_10_0_11));
        idle(1'b0, 1'b0);
        check("lu3_run", 32'(obs_c), 32'(9'b1111_00_0_00));
        check("lu3_stall2", 32'(sc_c), 32'd4);

        // LU_BUBBLES = 2: memory freeze while one bubble is still owed.
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 1'b0);
        hazard_rd3();
        check("lu2_hz", 32'(obs_b), 32'(9'b0111_10_0_00));
        for (int k = 0; k < 4; k++) begin
            idle(1'b1, 1'b0);
            check($sformatf("lu2_freeze%0d", k), 32'(obs_b), 32'(9'b0000_00_0_01));
        end
        idle(1'b0, 1'b0);
        check("lu2_last_bubble", 32'(obs_b), 32'(9'b0111_10_0_01));
        hazard_rd3();
        check("lu2_backtoback", 32'(obs_b), 32'(9'b0111_10_0_00));
        check("lu2_stall", 32'(sc_b), 32'd6);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Saturation of the stall counter.
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 1'b0);
        for (int k = 0; k < 65534; k++) begin
            idle(1'b1, 1'b0);
        end
        idle(1'b0, 1'b0);
        check("sat_fffe", 32'(sc_a), 32'h0000_FFFE);
        check("sat_state", 32'(obs_a), 32'(9'b1111_00_0_10));
        for (int k = 0; k < 5; k++) begin
            idle(1'b1, 1'b0);
        end
        idle(1'b0, 1'b0);
        check("sat_ffff", 32'(sc_a), 32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
